// File: rtl/bp_be_dcache_port_arb_if.sv
// ---------------------------------------------------------------------------
// bp_be_dcache_port_arb_if
//   Bundles the request/ptag/response signals around the single D$ port:
//   the pipe requester, the page-table-walker requester and the D$ itself.
//   Signal names keep their direction suffix as seen from the arbiter.
//
//   slave  modport : the arbiter side (takes *_i, drives *_o)
//   master modport : the environment side (drives *_i, takes *_o)
// ---------------------------------------------------------------------------
interface bp_be_dcache_port_arb_if #(
  parameter int dcache_pkt_width_p = 64,
  parameter int ptag_width_p       = 28
);

  // Pipe requester
  logic                          pipe_v_i;
  logic [dcache_pkt_width_p-1:0] pipe_pkt_i;
  logic                          pipe_ready_o;
  logic [ptag_width_p-1:0]       pipe_ptag_i;
  logic                          pipe_ptag_v_i;
  logic                          pipe_early_v_o;

  // Page-table-walker requester
  logic                          ptw_v_i;
  logic [dcache_pkt_width_p-1:0] ptw_pkt_i;
  logic                          ptw_ready_o;
  logic [ptag_width_p-1:0]       ptw_ptag_i;
  logic                          ptw_ptag_v_i;
  logic                          ptw_early_v_o;

  // D$ port
  logic                          dc_v_o;
  logic [dcache_pkt_width_p-1:0] dc_pkt_o;
  logic                          dc_ready_i;
  logic [ptag_width_p-1:0]       dc_ptag_o;
  logic                          dc_ptag_v_o;
  logic                          dc_early_v_i;

  modport slave (
    input  pipe_v_i, pipe_pkt_i, pipe_ptag_i, pipe_ptag_v_i,
    input  ptw_v_i, ptw_pkt_i, ptw_ptag_i, ptw_ptag_v_i,
    input  dc_ready_i, dc_early_v_i,
    output pipe_ready_o, pipe_early_v_o,
    output ptw_ready_o, ptw_early_v_o,
    output dc_v_o, dc_pkt_o, dc_ptag_o, dc_ptag_v_o
  );

  modport master (
    output pipe_v_i, pipe_pkt_i, pipe_ptag_i, pipe_ptag_v_i,
    output ptw_v_i, ptw_pkt_i, ptw_ptag_i, ptw_ptag_v_i,
    output dc_ready_i, dc_early_v_i,
    input  pipe_ready_o, pipe_early_v_o,
    input  ptw_ready_o, ptw_early_v_o,
    input  dc_v_o, dc_pkt_o, dc_ptag_o, dc_ptag_v_o
  );

endinterface

// File: rtl/bp_be_dcache_port_arb.sv
// ---------------------------------------------------------------------------
// bp_be_dcache_port_arb
//   Time-shares the single D$ request port between the load/store pipe and
//   the page-table walker. Every accepted request is tracked through the two
//   D$ stages (s1: ptag supply, s2: early response) so that the ptag and the
//   early valid are steered to the requester that issued it. A four-state
//   FSM (PIPE, DRAIN, PTW, RELEASE) hands the port over without mixing
//   owners; a flush kills only pipe-owned in-flight requests.
//
// Ports
//   clk_i, reset_n_i   : clock, asynchronous active-low reset
//   flush_i            : kill pipe-owned requests in s1/s2
//   ptw_busy_i         : a page walk is in progress
//   ptw_stall_cnt_o    : saturating count of pipe cycles held off by the PTW
//   port_if (slave)    : pipe / PTW / D$ request, ptag and response signals
// ---------------------------------------------------------------------------
module bp_be_dcache_port_arb #(
  parameter int dcache_pkt_width_p = 64,
  parameter int ptag_width_p       = 28
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    flush_i,
  input  logic                    ptw_busy_i,
  output logic [15:0]             ptw_stall_cnt_o,
  bp_be_dcache_port_arb_if.slave  port_if
);

  typedef enum logic [1:0] {
    ST_PIPE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_PTW     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic SRC_PIPE = 1'b0;
  localparam logic SRC_PTW  = 1'b1;

  state_e r_state;
  state_e w_state_next;

  // Stage slots: valid + owner of the request occupying each D$ stage.
  logic r_s1_v;
  logic r_s1_src;
  logic r_s2_v;
  logic r_s2_src;

  logic [15:0] r_stall_cnt;

  logic w_s1_v;
  logic w_s2_v;
  logic w_pipe_live;
  logic w_ptw_live;
  logic w_pipe_ready;
  logic w_ptw_ready;
  logic w_dc_v;
  logic w_acc_src;
  logic w_accept;
  logic w_stall_inc;
  logic w_s1_sel_ptw;
  logic [dcache_pkt_width_p-1:0] w_dc_pkt;
  logic [ptag_width_p-1:0]       w_ptag_sel;
  logic                          w_ptag_v_sel;

  // A flush knocks pipe-owned slots out in the same cycle, so every consumer
  // of the slot valids (ptag valid, response routing, FSM liveness, the s2
  // load) sees the post-kill view.
  assign w_s1_v = r_s1_v & ~(flush_i & (r_s1_src == SRC_PIPE));
  assign w_s2_v = r_s2_v & ~(flush_i & (r_s2_src == SRC_PIPE));

  assign w_pipe_live = (w_s1_v & (r_s1_src == SRC_PIPE))
                     | (w_s2_v & (r_s2_src == SRC_PIPE));
  assign w_ptw_live  = (w_s1_v & (r_s1_src == SRC_PTW))
                     | (w_s2_v & (r_s2_src == SRC_PTW));

  // -------------------------------------------------------------------------
  // Ownership FSM: next state and grant outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pipe_ready = 1'b0;
    w_ptw_ready  = 1'b0;
    w_dc_v       = 1'b0;
    w_dc_pkt     = port_if.pipe_pkt_i;
    w_acc_src    = SRC_PIPE;

    unique case (r_state)
      ST_PIPE: begin
        w_pipe_ready = port_if.dc_ready_i & ~ptw_busy_i;
        w_dc_v       = port_if.pipe_v_i & w_pipe_ready & ~flush_i;
        // No pipe grant is possible while busy, so the only pipe slots that
        // can still be in flight are the ones visible right now.
        if (ptw_busy_i) begin
          w_state_next = w_pipe_live ? ST_DRAIN : ST_PTW;
        end
      end

      ST_DRAIN: begin
        // A walk that gives up before the pipe drains hands straight back.
        if (!ptw_busy_i) begin
          w_state_next = ST_PIPE;
        end else if (!w_pipe_live) begin
          w_state_next = ST_PTW;
        end
      end

      ST_PTW: begin
        w_ptw_ready = port_if.dc_ready_i;
        w_dc_v      = port_if.ptw_v_i & port_if.dc_ready_i;
        w_dc_pkt    = port_if.ptw_pkt_i;
        w_acc_src   = SRC_PTW;
        if (!ptw_busy_i) begin
          w_state_next = w_ptw_live ? ST_RELEASE : ST_PIPE;
        end
      end

      ST_RELEASE: begin
        if (ptw_busy_i) begin
          w_state_next = ST_PTW;
        end else if (!w_ptw_live) begin
          w_state_next = ST_PIPE;
        end
      end

      default: begin
        w_state_next = ST_PIPE;
      end
    endcase
  end

  // w_dc_v already includes dc_ready_i in every granting state.
  assign w_accept = w_dc_v & reset_n_i;

  // -------------------------------------------------------------------------
  // Ptag mux (stage 1) and response routing (stage 2)
  // -------------------------------------------------------------------------
  // An empty or killed s1 defaults the mux to the pipe side.
  assign w_s1_sel_ptw = w_s1_v & (r_s1_src == SRC_PTW);

  always_comb begin
    w_ptag_sel   = port_if.pipe_ptag_i;
    w_ptag_v_sel = port_if.pipe_ptag_v_i;
    if (w_s1_sel_ptw) begin
      w_ptag_sel   = port_if.ptw_ptag_i;
      w_ptag_v_sel = port_if.ptw_ptag_v_i;
    end
  end

  assign port_if.dc_ptag_o   = w_ptag_sel;
  assign port_if.dc_ptag_v_o = w_s1_v & w_ptag_v_sel;

  assign port_if.pipe_early_v_o = port_if.dc_early_v_i & w_s2_v & (r_s2_src == SRC_PIPE);
  assign port_if.ptw_early_v_o  = port_if.dc_early_v_i & w_s2_v & (r_s2_src == SRC_PTW);

  // Ready/valid are purely combinational from the inputs, so they are forced
  // low while reset is held rather than waiting for a clock edge.
  assign port_if.pipe_ready_o = reset_n_i & w_pipe_ready;
  assign port_if.ptw_ready_o  = reset_n_i & w_ptw_ready;
  assign port_if.dc_v_o       = reset_n_i & w_dc_v;
  assign port_if.dc_pkt_o     = w_dc_pkt;

  // -------------------------------------------------------------------------
  // Stall counter: a pipe request is held off whenever the pipe does not own
  // the port, or owns it but a walk is blocking new grants.
  // -------------------------------------------------------------------------
  assign w_stall_inc = port_if.pipe_v_i & ((r_state != ST_PIPE) | ptw_busy_i);

  assign ptw_stall_cnt_o = r_stall_cnt;

  // -------------------------------------------------------------------------
  // State, slots and counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= ST_PIPE;
      r_s1_v      <= 1'b0;
      r_s1_src    <= SRC_PIPE;
      r_s2_v      <= 1'b0;
      r_s2_src    <= SRC_PIPE;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state  <= w_state_next;
      // The D$ stages advance every cycle regardless of dc_ready_i.
      r_s1_v   <= w_accept;
      r_s1_src <= w_acc_src;
      r_s2_v   <= w_s1_v;
      r_s2_src <= r_s1_src;
      if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bp_be_dcache_port_arb.sv
// ---------------------------------------------------------------------------
// tb_bp_be_dcache_port_arb
//   Drives the arbiter with directed scenarios and random traffic; every
//   cycle the outputs are compared with a reference model that tracks the
//   port owner and a list of in-flight requests tagged with owner and age.
// ---------------------------------------------------------------------------
module tb_bp_be_dcache_port_arb;

  localparam int PW = 64;
  localparam int TW = 28;

  localparam int M_PIPE  = 0;
  localparam int M_DRAIN = 1;
  localparam int M_PTW   = 2;
  localparam int M_REL   = 3;

  localparam bit S_PIPE = 1'b0;
  localparam bit S_PTW  = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        busy;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  bp_be_dcache_port_arb_if #(.dcache_pkt_width_p(PW), .ptag_width_p(TW)) arb_if ();

  bp_be_dcache_port_arb #(.dcache_pkt_width_p(PW), .ptag_width_p(TW)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .flush_i         (flush),
    .ptw_busy_i      (busy),
    .ptw_stall_cnt_o (stall_cnt),
    .port_if         (arb_if)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit src;
    int age;
  } fl_t;

  fl_t q[$];
  int  m_mode;
  int  m_cnt;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit live(input bit s);
    bit r = 1'b0;
    foreach (q[i]) if (q[i].src == s) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode = M_PIPE;
    m_cnt  = 0;
  endtask

  // Called just after a negedge once the inputs for this cycle are driven.
  task automatic step(input bit do_chk);
    fl_t          nq[$];
    fl_t          e;
    bit           pr, wr, dv, ptagv, pe, we, acc_src;
    logic [TW-1:0] ptag;
    #1;
    if (flush) begin
      foreach (q[i]) if (q[i].src != S_PIPE) nq.push_back(q[i]);
      q = nq;
      nq.delete();
    end
    pr = (m_mode == M_PIPE) && arb_if.dc_ready_i && !busy;
    wr = (m_mode == M_PTW) && arb_if.dc_ready_i;
    dv = (pr && arb_if.pipe_v_i && !flush) || (wr && arb_if.ptw_v_i);
    acc_src = (m_mode == M_PTW) ? S_PTW : S_PIPE;
    ptag = arb_if.pipe_ptag_i;
    ptagv = 1'b0; pe = 1'b0; we = 1'b0;
    foreach (q[i]) begin
      if (q[i].age == 1) begin
        if (q[i].src == S_PTW) begin
          ptag  = arb_if.ptw_ptag_i;
          ptagv = arb_if.ptw_ptag_v_i;
        end else begin
          ptagv = arb_if.pipe_ptag_v_i;
        end
      end else if (arb_if.dc_early_v_i) begin
        if (q[i].src == S_PTW) we = 1'b1; else pe = 1'b1;
      end
    end
    if (do_chk) begin
      chk("pipe_ready", arb_if.pipe_ready_o, pr);
      chk("ptw_ready", arb_if.ptw_ready_o, wr);
      chk("dc_v", arb_if.dc_v_o, dv);
      if (dv) chk("dc_pkt", arb_if.dc_pkt_o, (acc_src == S_PTW) ? arb_if.ptw_pkt_i : arb_if.pipe_pkt_i);
      chk("dc_ptag_v", arb_if.dc_ptag_v_o, ptagv);
      chk("dc_ptag", arb_if.dc_ptag_o, ptag);
      chk("pipe_early", arb_if.pipe_early_v_o, pe);
      chk("ptw_early", arb_if.ptw_early_v_o, we);
      chk("stall_cnt", stall_cnt, m_cnt);
    end
    if (dv) $display("ACCEPT t=%0t src=%s pkt=%h", $time, (acc_src == S_PTW) ? "PTW " : "PIPE",
                     (acc_src == S_PTW) ? arb_if.ptw_pkt_i : arb_if.pipe_pkt_i);
    // owner transitions, judged on the post-kill in-flight list
    case (m_mode)
      M_PIPE:  if (busy) m_mode = live(S_PIPE) ? M_DRAIN : M_PTW;
      M_DRAIN: if (!busy) m_mode = M_PIPE; else if (!live(S_PIPE)) m_mode = M_PTW;
      M_PTW:   if (!busy) m_mode = live(S_PTW) ? M_REL : M_PIPE;
      default: if (busy) m_mode = M_PTW; else if (!live(S_PTW)) m_mode = M_PIPE;
    endcase
    if (arb_if.pipe_v_i && ((m_mode_prev_not_pipe(pr, wr)) || busy) && m_cnt < 65535) m_cnt++;
    foreach (q[i]) if (q[i].age == 1) begin
      e.src = q[i].src; e.age = 2; nq.push_back(e);
    end
    if (dv) begin
      e.src = acc_src; e.age = 1; nq.push_back(e);
    end
    q = nq;
  endtask

  // The owner before this cycle's transition: PIPE is the only mode in which
  // the pipe-ready equation can be evaluated without a grant to the PTW.
  bit cur_not_pipe;
  function automatic bit m_mode_prev_not_pipe(input bit pr, input bit wr);
    return cur_not_pipe;
  endfunction

  task automatic drv(input bit pv, input bit wv, input bit b, input bit f,
                     input bit r, input bit ev);
    @(negedge clk);
    arb_if.pipe_v_i      = pv;
    arb_if.ptw_v_i       = wv;
    busy                 = b;
    flush                = f;
    arb_if.dc_ready_i    = r;
    arb_if.dc_early_v_i  = ev;
    arb_if.pipe_pkt_i    = {$urandom, $urandom};
    arb_if.ptw_pkt_i     = {$urandom, $urandom};
    arb_if.pipe_ptag_i   = TW'($urandom);
    arb_if.ptw_ptag_i    = TW'($urandom);
    arb_if.pipe_ptag_v_i = 1'b1;
    arb_if.ptw_ptag_v_i  = 1'b1;
    cur_not_pipe = (m_mode != M_PIPE);
    step(1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    busy    = 1'b0;
    arb_if.pipe_v_i = 1'b1;  arb_if.pipe_pkt_i = '0;
    arb_if.pipe_ptag_i = '0; arb_if.pipe_ptag_v_i = 1'b1;
    arb_if.ptw_v_i = 1'b1;   arb_if.ptw_pkt_i = '0;
    arb_if.ptw_ptag_i = '0;  arb_if.ptw_ptag_v_i = 1'b1;
    arb_if.dc_ready_i = 1'b1; arb_if.dc_early_v_i = 1'b1;
    model_reset();
    cur_not_pipe = 1'b0;

    // reset state: requests pending but nothing may be granted
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pipe_ready", arb_if.pipe_ready_o, 1'b0);
    chk("rst_dc_v", arb_if.dc_v_o, 1'b0);
    chk("rst_ptag_v", arb_if.dc_ptag_v_o, 1'b0);
    chk("rst_pipe_early", arb_if.pipe_early_v_o, 1'b0);
    chk("rst_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    arb_if.pipe_v_i = 1'b0;
    arb_if.ptw_v_i  = 1'b0;
    step(1'b1);

    // back-to-back pipe loads
    repeat (3) drv(1, 0, 0, 0, 1, 1);
    repeat (3) drv(0, 0, 0, 0, 1, 1);

    // walk start with pipe requests in s1/s2, then PTW traffic
    repeat (2) drv(1, 0, 0, 0, 1, 1);
    repeat (6) drv(0, 1, 1, 0, 1, 1);

    // walk ends with one PTW slot in s2 -> release, then pipe again
    drv(0, 1, 1, 0, 1, 1);
    drv(0, 0, 1, 0, 1, 1);
    drv(0, 0, 1, 0, 1, 1);
    drv(0, 1, 1, 0, 1, 1);
    drv(0, 0, 1, 0, 1, 1);
    drv(1, 0, 0, 0, 1, 1);
    repeat (3) drv(1, 0, 0, 0, 1, 1);

    // flush during drain
    drv(1, 0, 0, 0, 1, 1);
    drv(0, 0, 1, 0, 1, 1);
    drv(0, 0, 1, 1, 1, 1);
    repeat (3) drv(0, 1, 1, 0, 1, 1);
    repeat (3) drv(1, 0, 0, 0, 1, 1);

    // flush in PIPE with busy kills the only live slot
    drv(1, 0, 0, 0, 1, 1);
    drv(1, 0, 1, 1, 1, 1);
    repeat (3) drv(1, 1, 1, 0, 1, 1);
    repeat (4) drv(1, 0, 0, 0, 1, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) busy = ~busy;
      flush                = ($urandom_range(0, 9) == 0);
      arb_if.pipe_v_i      = $urandom_range(0, 1);
      arb_if.ptw_v_i       = $urandom_range(0, 1);
      arb_if.dc_ready_i    = ($urandom_range(0, 4) != 0);
      arb_if.dc_early_v_i  = ($urandom_range(0, 9) < 7);
      arb_if.pipe_pkt_i    = {$urandom, $urandom};
      arb_if.ptw_pkt_i     = {$urandom, $urandom};
      arb_if.pipe_ptag_i   = TW'($urandom);
      arb_if.ptw_ptag_i    = TW'($urandom);
      arb_if.pipe_ptag_v_i = $urandom_range(0, 1);
      arb_if.ptw_ptag_v_i  = $urandom_range(0, 1);
      cur_not_pipe = (m_mode != M_PIPE);
      step(1'b1);
    end

    // stall counter saturation while the PTW owns the port
    repeat (8) drv(0, 0, 1, 0, 1, 0);
    chk("sat_in_ptw", arb_if.ptw_ready_o, 1'b1);
    for (int i = 0; i < 66000; i++) begin
      @(negedge clk);
      arb_if.pipe_v_i = 1'b1;
      arb_if.ptw_v_i  = 1'b0;
      busy            = 1'b1;
      flush           = 1'b0;
      cur_not_pipe = (m_mode != M_PIPE);
      step(1'b0);
    end
    chk("stall_sat", stall_cnt, 16'hFFFF);
    repeat (3) drv(1, 0, 1, 0, 1, 0);
    chk("stall_nowrap", stall_cnt, 16'hFFFF);

    // asynchronous reset in the middle of a walk
    repeat (2) drv(0, 1, 1, 0, 1, 0);
    @(negedge clk);
    busy = 1'b0; flush = 1'b0;
    arb_if.pipe_v_i = 1'b1; arb_if.ptw_v_i = 1'b1;
    arb_if.dc_ready_i = 1'b1; arb_if.dc_early_v_i = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pipe_ready", arb_if.pipe_ready_o, 1'b0);
    chk("arst_ptw_ready", arb_if.ptw_ready_o, 1'b0);
    chk("arst_dc_v", arb_if.dc_v_o, 1'b0);
    chk("arst_ptag_v", arb_if.dc_ptag_v_o, 1'b0);
    chk("arst_pipe_early", arb_if.pipe_early_v_o, 1'b0);
    chk("arst_ptw_early", arb_if.ptw_early_v_o, 1'b0);
    chk("arst_cnt", stall_cnt, 16'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    arb_if.pipe_v_i = 1'b0;
    arb_if.ptw_v_i  = 1'b0;
    cur_not_pipe = 1'b0;
    step(1'b1);
    repeat (4) drv(1, 0, 0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
